// File: rtl/ttl_bank_controller.sv
// TTL channel bank: commands queue in a FIFO and execute on timestamp match.
// Pulse mode (01) is built only when TTL_BANK_PULSE_EN is defined.
module ttl_bank_controller #(
  parameter int NUM_CH     = 8,
  parameter int PW_WIDTH   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [127:0]      cmd_data,
  input  logic              counter_matched,
  input  logic              override_en,
  input  logic [63:0]       override_value,
  output logic [NUM_CH-1:0] ttl_out,
  output logic              overrided,
  output logic              busy_error,
  output logic [127:0]      error_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  logic [127:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push;
  logic              pop;
  logic              reject;
  logic [127:0]      head;

  logic [1:0]        mode;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] val;
  logic              is_set;
  logic              is_tog;
  logic              is_pulse;

  logic [NUM_CH-1:0] state;
  logic [NUM_CH-1:0] state_d;
  logic              mode_err;

  logic              unused_ov;

  assign cmd_ready = (count < FULL);
  assign push      = cmd_valid && cmd_ready;
  // A pop in the same cycle never frees room for a write while full.
  assign reject    = cmd_valid && !cmd_ready;
  assign pop       = counter_matched && (count != '0);
  assign head      = mem[rd_ptr];

  assign mode   = head[81:80];
  assign mask   = head[NUM_CH-1:0];
  assign val    = head[32 +: NUM_CH];
  assign is_set = (mode == 2'b00);
  assign is_tog = (mode == 2'b10);

  assign unused_ov = ^override_value[63:NUM_CH];

`ifdef TTL_BANK_PULSE_EN
  logic [PW_WIDTH-1:0] cnt   [NUM_CH];
  logic [PW_WIDTH-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0]   act;
  logic [NUM_CH-1:0]   act_d;
  logic [PW_WIDTH-1:0] pw_raw;
  logic [PW_WIDTH-1:0] pw_eff;

  assign is_pulse = (mode == 2'b01);
  assign pw_raw   = head[64 +: PW_WIDTH];
  assign pw_eff   = (pw_raw == '0) ? PW_WIDTH'(1) : pw_raw;
`else
  logic [PW_WIDTH-1:0] unused_pw;

  assign is_pulse  = 1'b0;
  assign unused_pw = head[64 +: PW_WIDTH];
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd_data;
    end
  end

  always_comb begin
    state_d  = state;
    mode_err = 1'b0;
`ifdef TTL_BANK_PULSE_EN
    act_d = act;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt[i];
      if (act[i]) begin
        if (cnt[i] == PW_WIDTH'(1)) begin
          state_d[i] = ~state[i];
          act_d[i]   = 1'b0;
        end else begin
          cnt_d[i] = cnt[i] - 1'b1;
        end
      end
    end
`endif
    if (pop) begin
      unique case (1'b1)
        is_set: begin
          state_d = (state_d & ~mask) | (val & mask);
`ifdef TTL_BANK_PULSE_EN
          act_d = act_d & ~mask;
`endif
        end
        is_tog: begin
          // Invert the pre-edge level so an expiring pulse cannot double-flip.
          state_d = (state_d & ~mask) | (~state & mask);
`ifdef TTL_BANK_PULSE_EN
          act_d = act_d & ~mask;
`endif
        end
        is_pulse: begin
`ifdef TTL_BANK_PULSE_EN
          state_d = (state_d & ~mask) | (val & mask);
          act_d   = act_d | mask;
          for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i]) begin
              cnt_d[i] = pw_eff;
            end
          end
`endif
        end
        default: mode_err = 1'b1;
      endcase
    end
  end

`ifdef TTL_BANK_PULSE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      act <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      act <= act_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= cnt_d[i];
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= '0;
      ttl_out    <= '0;
      overrided  <= 1'b0;
      busy_error <= 1'b0;
      error_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      state      <= state_d;
      ttl_out    <= override_en ? override_value[NUM_CH-1:0] : state;
      overrided  <= override_en;
      busy_error <= reject | mode_err;
      if (reject) begin
        error_data <= cmd_data;
      end else if (mode_err) begin
        error_data <= head;
      end
    end
  end

endmodule

// File: tb/tb_ttl_bank_controller.sv
// Scoreboard bench for ttl_bank_controller: directed commands, queued
// expectations checked by a negedge monitor.
module tb_ttl_bank_controller;

  localparam int NUM_CH = 8;
  localparam int TTL = 0;
  localparam int RDY = 1;
  localparam int BSY = 2;
  localparam int OVR = 3;
  localparam int ERR = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [127:0]      cmd_data = '0;
  logic              counter_matched = 1'b0;
  logic              override_en = 1'b0;
  logic [63:0]       override_value = '0;
  logic [NUM_CH-1:0] ttl_out;
  logic              overrided;
  logic              busy_error;
  logic [127:0]      error_data;

  ttl_bank_controller #(
    .NUM_CH(NUM_CH),
    .PW_WIDTH(16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data(cmd_data),
    .counter_matched(counter_matched),
    .override_en(override_en),
    .override_value(override_value),
    .ttl_out(ttl_out),
    .overrided(overrided),
    .busy_error(busy_error),
    .error_data(error_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    int           sel;
    logic [127:0] exp;
    string        nm;
  } chk_t;

  chk_t         chk_q[$];
  logic [127:0] err_q[$];
  logic [127:0] err_exp;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  bit           done = 1'b0;
  bit           final_done = 1'b0;
  int           c;
  int           d;
  int           e;
  logic [127:0] cmd_a;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] sample(int sel);
    case (sel)
      TTL:     return 128'(ttl_out);
      RDY:     return 128'(cmd_ready);
      BSY:     return 128'(busy_error);
      OVR:     return 128'(overrided);
      default: return error_data;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = chk_q.size() - 1; i >= 0; i--) begin
      if (chk_q[i].due <= cyc) begin
        checks++;
        if (sample(chk_q[i].sel) !== chk_q[i].exp) begin
          errors++;
          $display("FAIL %s cyc %0d got %0h want %0h", chk_q[i].nm, cyc,
                   sample(chk_q[i].sel), chk_q[i].exp);
        end
        chk_q.delete(i);
      end
    end
    if (busy_error === 1'b1) begin
      checks++;
      if (err_q.size() == 0) begin
        errors++;
        $display("FAIL busy_unexpected cyc %0d got 1 want 0", cyc);
      end else begin
        err_exp = err_q.pop_front();
        if (error_data !== err_exp) begin
          errors++;
          $display("FAIL error_data cyc %0d got %0h want %0h", cyc,
                   error_data, err_exp);
        end
      end
    end
    if (done && !final_done) begin
      final_done = 1'b1;
      checks++;
      if (chk_q.size() != 0 || err_q.size() != 0) begin
        errors++;
        $display("FAIL leftover got %0d/%0d want 0/0", chk_q.size(),
                 err_q.size());
      end
    end
  end

  function automatic logic [127:0] mk(logic [1:0] m, logic [31:0] msk,
                                       logic [31:0] v, logic [15:0] pw);
    return {46'h2a5, m, pw, v, msk};
  endfunction

  function automatic logic [127:0] cmd_n(int i);
    return mk(2'b00, 32'd1 << i, 32'd1 << i, 16'd0);
  endfunction

  task automatic exp_at(int due, int sel, logic [127:0] v, string nm);
    chk_q.push_back('{due, sel, v, nm});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [127:0] data);
    cmd_valid = 1'b1;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic match1();
    counter_matched = 1'b1;
    tick();
    counter_matched = 1'b0;
  endtask

  task automatic do_reset();
    int r;
    reset = 1'b1;
    tick();
    tick();
    r = cyc;
    exp_at(r + 1, TTL, 0, "rst_ttl");
    exp_at(r + 1, RDY, 1, "rst_ready");
    exp_at(r + 1, BSY, 0, "rst_busy");
    exp_at(r + 1, OVR, 0, "rst_ovr");
    exp_at(r + 1, ERR, 0, "rst_errdata");
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // set: mask/value 0x05
    do_reset();
    push(mk(2'b00, 32'h05, 32'h05, 16'd0));
    d = cyc;
    exp_at(d + 1, TTL, 8'h00, "set_lat1");
    exp_at(d + 2, TTL, 8'h05, "set_out");
    match1();
    tick();
    // mask bits above NUM_CH only
    push(mk(2'b00, 32'hFFFF_FF00, 32'hFFFF_FFFF, 16'd0));
    d = cyc;
    exp_at(d + 2, TTL, 8'h05, "high_mask");
    match1();
    tick();
    // toggle low two channels
    push(mk(2'b10, 32'h03, 32'h00, 16'd0));
    d = cyc;
    exp_at(d + 2, TTL, 8'h06, "toggle");
    match1();
    tick();

    // override during toggle
    do_reset();
    push(mk(2'b10, 32'h0F, 32'h00, 16'd0));
    d = cyc;
    override_en     = 1'b1;
    override_value  = 64'hFF;
    counter_matched = 1'b1;
    exp_at(d + 1, TTL, 8'hFF, "ovr_out1");
    exp_at(d + 1, OVR, 1, "ovr_flag");
    exp_at(d + 3, TTL, 8'hFF, "ovr_out3");
    exp_at(d + 4, TTL, 8'h0F, "ovr_release");
    exp_at(d + 4, OVR, 0, "ovr_flag_off");
    tick();
    counter_matched = 1'b0;
    tick();
    tick();
    override_en = 1'b0;
    tick();
    tick();

    // fill FIFO, reject fifth, reject with same-cycle pop, drain
    do_reset();
    c = cyc;
    exp_at(c + 3, RDY, 1, "ready_at3");
    exp_at(c + 4, RDY, 0, "ready_full");
    exp_at(c + 4, BSY, 0, "busy_pre");
    exp_at(c + 5, BSY, 1, "busy_full");
    exp_at(c + 6, BSY, 0, "busy_once");
    exp_at(c + 5, TTL, 8'h00, "full_ttl");
    err_q.push_back(cmd_n(4));
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = cmd_n(i);
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    exp_at(c + 7, BSY, 1, "busy_pop_full");
    exp_at(c + 7, RDY, 1, "ready_after_pop");
    exp_at(c + 8, BSY, 0, "busy_pop_end");
    exp_at(c + 8, TTL, 8'h01, "drain1");
    exp_at(c + 9, TTL, 8'h03, "drain2");
    exp_at(c + 10, TTL, 8'h07, "drain3");
    exp_at(c + 11, TTL, 8'h0F, "drain4");
    exp_at(c + 11, RDY, 1, "ready_empty");
    exp_at(c + 12, BSY, 0, "empty_match");
    exp_at(c + 13, TTL, 8'h0F, "empty_hold");
    err_q.push_back(cmd_n(5));
    cmd_valid       = 1'b1;
    cmd_data        = cmd_n(5);
    counter_matched = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    counter_matched = 1'b0;
    tick();
    tick();

    // reserved mode 11, then FIFO must be empty
    do_reset();
    cmd_a = mk(2'b11, 32'hFF, 32'hFF, 16'd7);
    push(cmd_a);
    d = cyc;
    err_q.push_back(cmd_a);
    exp_at(d + 1, BSY, 1, "m11_busy");
    exp_at(d + 1, ERR, cmd_a, "m11_data");
    exp_at(d + 2, BSY, 0, "m11_busy_end");
    exp_at(d + 3, TTL, 8'h00, "m11_ttl");
    match1();
    tick();
    push(mk(2'b00, 32'h80, 32'h80, 16'd0));
    e = cyc;
    exp_at(e + 2, TTL, 8'h80, "m11_next");
    exp_at(e + 2, ERR, cmd_a, "m11_hold");
    match1();
    tick();
    tick();

`ifdef TTL_BANK_PULSE_EN
    // pulse pw=3
    do_reset();
    push(mk(2'b01, 32'h01, 32'h01, 16'd3));
    d = cyc;
    exp_at(d + 1, TTL, 8'h00, "pls_lat");
    exp_at(d + 2, TTL, 8'h01, "pls_hi1");
    exp_at(d + 3, TTL, 8'h01, "pls_hi2");
    exp_at(d + 4, TTL, 8'h01, "pls_hi3");
    exp_at(d + 5, TTL, 8'h00, "pls_lo1");
    exp_at(d + 6, TTL, 8'h00, "pls_lo2");
    match1();
    repeat (6) tick();

    // reset during pw=10 pulse with a pending command
    do_reset();
    push(mk(2'b01, 32'h01, 32'h01, 16'd10));
    d = cyc;
    exp_at(d + 2, TTL, 8'h01, "rp_hi1");
    exp_at(d + 4, TTL, 8'h01, "rp_hi3");
    exp_at(d + 5, TTL, 8'h00, "rp_rst");
    exp_at(d + 5, RDY, 1, "rp_ready");
    for (int k = 6; k <= 16; k++) begin
      exp_at(d + k, TTL, 8'h00, "rp_aborted");
    end
    match1();
    push(mk(2'b00, 32'h02, 32'h02, 16'd0));
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    match1();
    repeat (12) tick();
`else
    // mode 01 is reserved in this build
    do_reset();
    cmd_a = mk(2'b01, 32'h01, 32'h01, 16'd3);
    push(cmd_a);
    d = cyc;
    err_q.push_back(cmd_a);
    exp_at(d + 1, BSY, 1, "m01_busy");
    exp_at(d + 2, BSY, 0, "m01_busy_end");
    exp_at(d + 2, TTL, 8'h00, "m01_ttl");
    exp_at(d + 3, TTL, 8'h00, "m01_ttl2");
    match1();
    repeat (3) tick();
`endif

    // reset clears state and pending FIFO entry
    do_reset();
    push(mk(2'b00, 32'h03, 32'h03, 16'd0));
    d = cyc;
    exp_at(d + 2, TTL, 8'h03, "rs_set");
    exp_at(d + 3, TTL, 8'h03, "rs_hold");
    exp_at(d + 4, TTL, 8'h00, "rs_clear");
    exp_at(d + 4, RDY, 1, "rs_ready");
    exp_at(d + 5, TTL, 8'h00, "rs_empty1");
    exp_at(d + 6, TTL, 8'h00, "rs_empty2");
    match1();
    push(mk(2'b00, 32'h04, 32'h04, 16'd0));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    match1();
    tick();
    tick();

    done = 1'b1;
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ttl_bank_controller.md
TTL_BANK_CONTROLLER -- requirements
Module: ttl_bank_controller

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of TTL channels, legal range 1..32.
REQ-002 SHALL have parameter PW_WIDTH, default 16, pulse-width counter width, legal range 1..16.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries, power of two, minimum 2.
REQ-004 SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port cmd_valid, input, 1 bit: command write strobe.
REQ-007 SHALL have port cmd_ready, output, 1 bit: FIFO not full.
REQ-008 SHALL have port cmd_data, input, 128 bits: [31:0] channel mask, [63:32] value, [79:64] pulse width, [81:80] mode (00 set, 01 pulse, 10 toggle, 11 reserved); other bits ignored.
REQ-009 SHALL have port counter_matched, input, 1 bit: timestamp match, executes FIFO head.
REQ-010 SHALL have port override_en, input, 1 bit: force outputs from override_value.
REQ-011 SHALL have port override_value, input, 64 bits: forced levels, bits [NUM_CH-1:0] used.
REQ-012 SHALL have port ttl_out, output, NUM_CH bits: registered channel outputs.
REQ-013 SHALL have port overrided, output, 1 bit: registered copy of override_en.
REQ-014 SHALL have port busy_error, output, 1 bit: one-cycle error pulse.
REQ-015 SHALL have port error_data, output, 128 bits: cmd_data of the last erroneous command.

Function
REQ-016 SHALL accept cmd_data into the FIFO when cmd_valid and cmd_ready are both 1; cmd_ready equals 1 when FIFO occupancy is below FIFO_DEPTH.
REQ-017 SHALL reject cmd_valid while full: command dropped, busy_error=1 next cycle, error_data=cmd_data; a same-cycle pop does not make room.
REQ-018 SHALL pop and execute the head when counter_matched=1 and FIFO is non-empty; counter_matched with FIFO empty is ignored, no error.
REQ-019 SHALL keep an internal state register; an executed command updates state the cycle after the match, and ttl_out reflects it one cycle later (two-cycle match-to-pin latency).
REQ-020 SHALL, in mode 00, set each masked channel's state to its value bit and cancel any active pulse on that channel.
REQ-021 SHALL, in mode 10, invert each masked channel's state and cancel any active pulse on it.
REQ-022 SHALL, in mode 01, drive each masked channel to its value bit for max(pw,1) cycles, then to the complement; a new pulse on an active channel restarts its counter.
REQ-023 SHALL treat mode 11 as an error: the command is consumed with no state change, busy_error pulses, and error_data captures the command.
REQ-024 SHALL ignore mask bits at or above NUM_CH.
REQ-025 SHALL drive ttl_out=override_value[NUM_CH-1:0] while override_en=1, with one-cycle latency; commands and pulse counters continue on internal state, and ttl_out returns to internal state one cycle after override_en falls.
REQ-026 SHALL give priority to FIFO-full busy_error when full-reject and mode-11 errors occur in the same cycle; both are reported through a single busy_error pulse.

Reset
REQ-027 SHALL on reset clear FIFO and all pulse counters, set state and ttl_out to 0, overrided=0, busy_error=0, error_data=0, cmd_ready=1.
REQ-028 SHALL give reset priority over all inputs; reset mid-pulse aborts the pulse with output 0.

Configuration
REQ-029 SHALL compile pulse mode only when macro TTL_BANK_PULSE_EN is defined: with it, REQ-022 applies and per-channel PW_WIDTH counters exist.
REQ-030 SHALL, without TTL_BANK_PULSE_EN, treat mode 01 as reserved per REQ-023 and instantiate no pulse counters.

Verification
REQ-031 SHALL cover this scenario: reset, push mode00 mask=0x05 value=0x05, match → ttl_out=0x05 two cycles after the match.
REQ-032 SHALL cover this scenario: TTL_BANK_PULSE_EN, push mode01 mask=0x01 value=0x01 pw=3, match → ch0 high for exactly 3 cycles, then low.
REQ-033 SHALL cover this scenario: with FIFO_DEPTH=4, push 5 commands with no match → cmd_ready=0 after 4, fifth command in error_data, busy_error pulses once.
REQ-034 SHALL cover this scenario: override_en=1 value=0xFF during a mode10 mask=0x0F execution → ttl_out=0xFF; after release ttl_out=0x0F from state 0.
REQ-035 SHALL cover this scenario: push mode11, match → no output change, busy_error=1 for one cycle, and the FIFO empties.
REQ-036 SHALL cover this scenario: assert reset during a pw=10 pulse → ttl_out=0 the next cycle, FIFO empty, cmd_ready=1.
